// File: rtl/div_clock_monitor_if.sv
// Bundle of control inputs and status outputs for the divided-clock monitor.
// The master side drives the source and settings; the slave side is the monitor.
interface div_clock_monitor_if #(
  parameter int DIVCLK_WIDTH = 16
);
  logic                    enable;
  logic [DIVCLK_WIDTH-1:0] expected_div;
  logic                    div_clk_in;
  logic [DIVCLK_WIDTH-1:0] measured_div;
  logic                    measured_valid;
  logic                    locked;
  logic                    mismatch;
  logic                    timeout;

  modport master (
    output enable, expected_div, div_clk_in,
    input  measured_div, measured_valid, locked, mismatch, timeout
  );

  modport slave (
    input  enable, expected_div, div_clk_in,
    output measured_div, measured_valid, locked, mismatch, timeout
  );
endinterface

// File: rtl/div_clock_monitor.sv
// Recovers the divider of a toggling div_clk from half-period lengths in the clk
// domain and reports lock, mismatch and a sticky timeout.
module div_clock_monitor #(
  parameter int DIVCLK_WIDTH = 16,
  parameter int LOCK_COUNT   = 4,
  parameter int TIMEOUT_CYC  = 2**DIVCLK_WIDTH + 2
) (
  input logic               clk,
  input logic               reset,
  div_clock_monitor_if.slave bus
);
  localparam int CW = DIVCLK_WIDTH + 2;
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0] DIV_MAX = {2'b00, {DIVCLK_WIDTH{1'b1}}};
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [MW-1:0] LOCK_N  = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, LOCKED} state_t;

  state_t                  state, state_n;
  logic                    sync1, sync2, hist;
  logic                    dclk_edge;
  logic [CW-1:0]           cnt, cnt_n, cnt_inc, rec_full;
  logic [DIVCLK_WIDTH-1:0] rec, mdiv, mdiv_n;
  logic                    sat, is_match;
  logic [MW-1:0]           mcnt, mcnt_n, mcnt_inc;
  logic                    mv, mv_n, mism, mism_n, lck, lck_n, tmo, tmo_n;

  // div_clk is asynchronous: two sync flops, then a history flop for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= bus.div_clk_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign dclk_edge = sync2 ^ hist;
  assign cnt_inc   = (&cnt) ? cnt : cnt + ONE;
  assign rec_full  = cnt - ONE;
  assign sat       = rec_full > DIV_MAX;
  assign rec       = sat ? {DIVCLK_WIDTH{1'b1}} : rec_full[DIVCLK_WIDTH-1:0];
  // a clamped interval never matches, even when expected_div is all ones
  assign is_match  = !sat && (rec == bus.expected_div);
  assign mcnt_inc  = mcnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      mdiv  <= '0;
      mcnt  <= '0;
      mv    <= 1'b0;
      mism  <= 1'b0;
      lck   <= 1'b0;
      tmo   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      mdiv  <= mdiv_n;
      mcnt  <= mcnt_n;
      mv    <= mv_n;
      mism  <= mism_n;
      lck   <= lck_n;
      tmo   <= tmo_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt_inc;
    mdiv_n  = mdiv;
    mcnt_n  = mcnt;
    mv_n    = 1'b0;
    mism_n  = 1'b0;
    lck_n   = lck;
    tmo_n   = tmo;
    if (!bus.enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      mdiv_n  = '0;
      mcnt_n  = '0;
      lck_n   = 1'b0;
      tmo_n   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_n = ARM;
          cnt_n   = ONE;
        end
        ARM: begin
          // first edge only starts the clock on intervals; its own interval is partial
          if (dclk_edge) begin
            state_n = MEASURE;
            cnt_n   = ONE;
          end else if (cnt == TO_VAL) begin
            tmo_n  = 1'b1;
            lck_n  = 1'b0;
            mcnt_n = '0;
          end
        end
        MEASURE, LOCKED: begin
          // an edge coinciding with the timeout count takes precedence
          if (dclk_edge) begin
            cnt_n  = ONE;
            mdiv_n = rec;
            mv_n   = 1'b1;
            if (is_match) begin
              if (state == MEASURE) begin
                mcnt_n = mcnt_inc;
                if (mcnt_inc == LOCK_N) begin
                  state_n = LOCKED;
                  lck_n   = 1'b1;
                end
              end
            end else begin
              mism_n  = 1'b1;
              mcnt_n  = '0;
              lck_n   = 1'b0;
              state_n = MEASURE;
            end
          end else if (cnt == TO_VAL) begin
            tmo_n   = 1'b1;
            lck_n   = 1'b0;
            mcnt_n  = '0;
            state_n = ARM;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.measured_div   = mdiv;
  assign bus.measured_valid = mv;
  assign bus.locked         = lck;
  assign bus.mismatch       = mism;
  assign bus.timeout        = tmo;
endmodule
